// File: rtl/button_conditioner_pkg.sv
// Shared types and defaults for the button conditioner and its debounce channels.
package button_conditioner_pkg;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } debounce_state_t;

   // 10 ms debounce and 0.5 s auto-repeat at a 50 MHz clock.
   localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 500000;
   localparam int unsigned DEFAULT_REPEAT_CYCLES   = 25000000;

endpackage

// File: rtl/button_conditioner_btn_debounce.sv
// One button channel: 2-flop synchronizer, debounce FSM and stability counter.
// o_accept is the single-cycle strobe the top registers into its output pulse.
module btn_debounce
   import button_conditioner_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_raw,
   output logic            o_accept,
   output logic            o_held,
   output debounce_state_t o_state
);

   localparam int unsigned CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic            r_s1;
   logic            r_s2;
   logic [CW-1:0]   r_cnt;
   logic            r_held;
   debounce_state_t r_state;

   // The counter only runs while waiting and restarts on every transition,
   // so it tops out at CNT_LAST and can never wrap.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1    <= 1'b0;
         r_s2    <= 1'b0;
         r_cnt   <= '0;
         r_held  <= 1'b0;
         r_state <= IDLE;
      end else begin
         r_s1 <= i_raw;
         r_s2 <= r_s1;
         case (r_state)
            IDLE: begin
               if (r_s2) begin
                  r_state <= PRESS_WAIT;
                  r_cnt   <= '0;
               end
            end
            PRESS_WAIT: begin
               if (!r_s2) begin
                  r_state <= IDLE;
                  r_cnt   <= '0;
               end else if (r_cnt == CNT_LAST) begin
                  r_state <= PRESSED;
                  r_cnt   <= '0;
                  r_held  <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            PRESSED: begin
               if (!r_s2) begin
                  r_state <= RELEASE_WAIT;
                  r_cnt   <= '0;
               end
            end
            RELEASE_WAIT: begin
               if (r_s2) begin
                  r_state <= PRESSED;
                  r_cnt   <= '0;
               end else if (r_cnt == CNT_LAST) begin
                  r_state <= IDLE;
                  r_cnt   <= '0;
                  r_held  <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            default: begin
               r_state <= IDLE;
               r_cnt   <= '0;
               r_held  <= 1'b0;
            end
         endcase
      end
   end

   assign o_accept = (r_state == PRESS_WAIT) && r_s2 && (r_cnt == CNT_LAST);
   assign o_held   = r_held;
   assign o_state  = r_state;

endmodule

// File: rtl/button_conditioner.sv
// Play/stop button front end: two debounce channels, stop-priority arbitration
// and registered one-cycle pulses. Define AUTO_REPEAT_EN for play auto-repeat.
module button_conditioner
   import button_conditioner_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int unsigned REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_play_raw,
   input  logic btn_stop_raw,
   output logic play,
   output logic stop,
   output logic play_held,
   output logic stop_held
);

   logic            w_playAccept;
   logic            w_stopAccept;
   logic            w_playReq;
   debounce_state_t w_playState;
   debounce_state_t w_stopState;
   logic            r_play;
   logic            r_stop;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_playDebounce (
      .clk      (clk),
      .rst      (rst),
      .i_raw    (btn_play_raw),
      .o_accept (w_playAccept),
      .o_held   (play_held),
      .o_state  (w_playState)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_stopDebounce (
      .clk      (clk),
      .rst      (rst),
      .i_raw    (btn_stop_raw),
      .o_accept (w_stopAccept),
      .o_held   (stop_held),
      .o_state  (w_stopState)
   );

`ifdef AUTO_REPEAT_EN
   localparam int unsigned RW = (REPEAT_CYCLES > 2) ? $clog2(REPEAT_CYCLES) : 1;
   localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

   logic [RW-1:0] r_repeatCnt;
   logic          w_repeatFire;
   logic          w_unusedStopState;

   assign w_repeatFire      = (w_playState == PRESSED) && (r_repeatCnt == REP_LAST);
   assign w_unusedStopState = ^w_stopState;

   // Counts cycles spent in PRESSED; any exit from PRESSED restarts the interval.
   always_ff @(posedge clk) begin
      if (rst || (w_playState != PRESSED) || w_repeatFire) begin
         r_repeatCnt <= '0;
      end else begin
         r_repeatCnt <= r_repeatCnt + RW'(1);
      end
   end

   assign w_playReq = w_playAccept | w_repeatFire;
`else
   logic w_unusedRepeat;

   assign w_unusedRepeat = (REPEAT_CYCLES >= 2) ^ (^w_playState) ^ (^w_stopState);
   assign w_playReq      = w_playAccept;
`endif

   // Stop wins a same-cycle collision; the losing play pulse is dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_play <= 1'b0;
         r_stop <= 1'b0;
      end else begin
         r_stop <= w_stopAccept;
         r_play <= w_playReq & ~w_stopAccept;
      end
   end

   assign play = r_play;
   assign stop = r_stop;

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: directed scenarios plus random
// button activity, compared every cycle against a run-length reference model.
module tb_button_conditioner;

   localparam int unsigned DEB = 4;
   localparam int unsigned REP = 10;

   logic clk = 1'b0;
   logic rst;
   logic btn_play_raw;
   logic btn_stop_raw;
   logic play;
   logic stop;
   logic play_held;
   logic stop_held;

   always #5 clk = ~clk;

   button_conditioner #(
      .DEBOUNCE_CYCLES (DEB),
      .REPEAT_CYCLES   (REP)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .btn_play_raw (btn_play_raw),
      .btn_stop_raw (btn_stop_raw),
      .play         (play),
      .stop         (stop),
      .play_held    (play_held),
      .stop_held    (stop_held)
   );

   int checks   = 0;
   int failures = 0;

   // Reference model: per channel, the synchronized level and how many
   // consecutive edges it has disagreed with the accepted level.
   bit mS1[2];
   bit mS2[2];
   bit mHeld[2];
   int mRun[2];
   int mRep;
   bit expPlay;
   bit expStop;
   int playCount;
   int stopCount;

   task automatic checkOutput(input string tag, input logic observed, input logic expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0b expected %0b at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic modelEdge(input bit p, input bit s, input bit r);
      bit accept[2];
      bit raw[2];
      bit fire;
      raw[0] = p;
      raw[1] = s;
      fire   = 1'b0;
      if (r) begin
         for (int ch = 0; ch < 2; ch++) begin
            mS1[ch]   = 1'b0;
            mS2[ch]   = 1'b0;
            mHeld[ch] = 1'b0;
            mRun[ch]  = 0;
         end
         mRep    = 0;
         expPlay = 1'b0;
         expStop = 1'b0;
         return;
      end
`ifdef AUTO_REPEAT_EN
      if (mHeld[0] && mRun[0] == 0) begin
         mRep++;
         if (mRep == int'(REP)) begin
            fire = 1'b1;
            mRep = 0;
         end
      end else begin
         mRep = 0;
      end
`endif
      for (int ch = 0; ch < 2; ch++) begin
         accept[ch] = 1'b0;
         if (mS2[ch] != mHeld[ch]) begin
            mRun[ch]++;
            if (mRun[ch] == int'(DEB) + 1) begin
               mHeld[ch]  = ~mHeld[ch];
               mRun[ch]   = 0;
               accept[ch] = mHeld[ch];
            end
         end else begin
            mRun[ch] = 0;
         end
         mS2[ch] = mS1[ch];
         mS1[ch] = raw[ch];
      end
      expStop = accept[1];
      expPlay = (accept[0] | fire) & ~accept[1];
   endtask

   task automatic applyStimulus(input bit p, input bit s, input bit r);
      btn_play_raw = p;
      btn_stop_raw = s;
      rst          = r;
      @(posedge clk);
      modelEdge(p, s, r);
      @(negedge clk);
      checkOutput("play", play, expPlay);
      checkOutput("stop", stop, expStop);
      checkOutput("play_held", play_held, mHeld[0]);
      checkOutput("stop_held", stop_held, mHeld[1]);
      if (play === 1'b1) playCount++;
      if (stop === 1'b1) stopCount++;
   endtask

   task automatic idle(input int n);
      repeat (n) applyStimulus(1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      bit bounce[13];
      bit p;
      bit s;
      bit r;
      int len;

      btn_play_raw = 1'b0;
      btn_stop_raw = 1'b0;
      rst          = 1'b1;
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b1);
      checkOutput("reset_play", play, 1'b0);
      checkOutput("reset_held", play_held | stop_held, 1'b0);
      idle(4);

      // Clean press: one pulse after edge 3+DEB.
      playCount = 0;
      stopCount = 0;
      for (int i = 1; i <= 12; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b0);
         if (i == 7) checkOutput("latency_pulse", play, 1'b1);
         if (i == 6) checkOutput("latency_early", play, 1'b0);
      end
      checkOutput("clean_one_pulse", playCount == 1, 1'b1);
      checkOutput("clean_no_stop", stopCount == 0, 1'b1);
      idle(10);

      // Bouncing press.
      playCount = 0;
      bounce = '{1, 1, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
      foreach (bounce[i]) applyStimulus(bounce[i], 1'b0, 1'b0);
      checkOutput("bounce_one_pulse", playCount == 1, 1'b1);
      idle(10);

      // Simultaneous press: stop wins.
      playCount = 0;
      stopCount = 0;
      repeat (10) applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput("both_stop_once", stopCount == 1, 1'b1);
      checkOutput("both_play_dropped", playCount == 0, 1'b1);
      checkOutput("both_held", play_held & stop_held, 1'b1);
      idle(10);

      // Reset mid-count, button still held afterwards.
      playCount = 0;
      repeat (5) applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b1);
      checkOutput("midreset_no_pulse", playCount == 0, 1'b1);
      repeat (10) applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("midreset_fresh_press", playCount == 1, 1'b1);
      idle(10);

      // Two separate presses, then a short release glitch inside a hold.
      playCount = 0;
      repeat (10) applyStimulus(1'b1, 1'b0, 1'b0);
      idle(10);
      repeat (10) applyStimulus(1'b1, 1'b0, 1'b0);
      idle(10);
      checkOutput("two_presses", playCount == 2, 1'b1);
      playCount = 0;
      repeat (10) applyStimulus(1'b1, 1'b0, 1'b0);
      repeat (2) applyStimulus(1'b0, 1'b0, 1'b0);
      repeat (10) applyStimulus(1'b1, 1'b0, 1'b0);
      idle(10);
      checkOutput("glitch_no_second", playCount == 1, 1'b1);

      // Long hold: auto-repeat when enabled.
      playCount = 0;
      repeat (42) applyStimulus(1'b1, 1'b0, 1'b0);
      idle(10);
`ifdef AUTO_REPEAT_EN
      checkOutput("long_hold_pulses", playCount == 4, 1'b1);
`else
      checkOutput("long_hold_pulses", playCount == 1, 1'b1);
`endif

      // Random button activity with occasional resets.
      for (int seg = 0; seg < 300; seg++) begin
         p   = 1'($urandom_range(0, 1));
         s   = 1'($urandom_range(0, 1));
         r   = ($urandom_range(0, 39) == 0);
         len = int'($urandom_range(1, 12));
         if (r) applyStimulus(p, s, 1'b1);
         repeat (len) applyStimulus(p, s, 1'b0);
      end
      idle(10);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
